sram_ctrl: RTL and testbench

SRAM_CTRL -- requirements
Module: sram_ctrl

---
 rtl/sram_ctrl_pkg.sv | 30 +++
 rtl/sram_ctrl_if.sv | 16 +
 rtl/sram_ctrl.sv | 122 ++++++++++++
 tb/tb_sram_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the SoC memory subsystem SRAM controller.
// Holds the state encoding, the SRAM geometry and the bus request payload.
package sram_ctrl_pkg;

    localparam int unsigned BUS_DW     = 32;
    localparam int unsigned BUS_SW     = BUS_DW / 8;
    localparam int unsigned SRAM_AW    = 10;
    localparam int unsigned SRAM_DEPTH = 1 << SRAM_AW;

    // Controller state encodings
    localparam logic [1:0] ST_INIT_ENC    = 2'd0;
    localparam logic [1:0] ST_IDLE_ENC    = 2'd1;
    localparam logic [1:0] ST_RD_WAIT_ENC = 2'd2;
    localparam logic [1:0] ST_RESP_ENC    = 2'd3;

    typedef enum logic [1:0] {
        ST_INIT    = ST_INIT_ENC,
        ST_IDLE    = ST_IDLE_ENC,
        ST_RD_WAIT = ST_RD_WAIT_ENC,
        ST_RESP    = ST_RESP_ENC
    } state_e;

    // Request payload carried alongside mem_valid
    typedef struct packed {
        logic [BUS_DW-1:0] addr;
        logic [BUS_DW-1:0] wdata;
        logic [BUS_SW-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// Simple valid/ready memory bus.
//   mem_valid : request valid, held by the master until mem_ready
//   mem_req   : byte address, write data, byte strobes (0 = read)
//   mem_ready : one-cycle completion pulse from the slave
//   mem_rdata : read data, valid with mem_ready for reads
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic              mem_valid;
    mem_req_t          mem_req;
    logic              mem_ready;
    logic [BUS_DW-1:0] mem_rdata;

    modport master (output mem_valid, output mem_req, input mem_ready, input mem_rdata);
    modport slave  (input mem_valid, input mem_req, output mem_ready, output mem_rdata);
endinterface

// File: rtl/sram_ctrl.sv
// Bus-to-SRAM controller for a single-port tc_sram_1024x32 style macro.
// Optionally zero-fills the SRAM after reset, then serves one bus request
// at a time: writes complete one cycle after issue, reads two.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   mem           : bus slave port (valid/req in, ready/rdata out)
//   init_done_o   : high once the zero-fill sweep has finished
//   sram_*_o      : SRAM macro controls (driven combinationally)
//   sram_data_i   : SRAM read data, one cycle after a read is issued
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = SRAM_AW,
    parameter bit          INIT_EN    = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    sram_ctrl_if.slave            mem,
    output logic                  init_done_o,
    output logic                  sram_cs_o,
    output logic                  sram_wren_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [BUS_DW-1:0]     sram_data_o,
    output logic [BUS_SW-1:0]     sram_mask_o,
    input  logic [BUS_DW-1:0]     sram_data_i
);

    localparam state_e                RST_STATE = INIT_EN ? ST_INIT : ST_IDLE;
    localparam logic [ADDR_WIDTH-1:0] CNT_LAST  = '1;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic [BUS_DW-1:0]       rdata_q, rdata_d;
    logic                    done_q, done_d;

    // Upper and sub-word address bits are decoded upstream
    logic unused_addr_bits;
    assign unused_addr_bits = ^{mem.mem_req.addr[BUS_DW-1:ADDR_WIDTH+2], mem.mem_req.addr[1:0]};

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            rdata_q <= '0;
            done_q  <= !INIT_EN;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            done_q  <= done_d;
        end
    end

    // Next state and SRAM controls
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = 1'b0;
        rdata_d     = rdata_q;
        done_d      = done_q;
        sram_cs_o   = 1'b0;
        sram_wren_o = 1'b0;
        sram_addr_o = '0;
        sram_data_o = '0;
        sram_mask_o = '0;

        unique case (state_q)
            ST_INIT: begin
                sram_cs_o   = 1'b1;
                sram_wren_o = 1'b1;
                sram_mask_o = '1;
                sram_addr_o = cnt_q;
                cnt_d       = cnt_q + ADDR_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            ST_IDLE: begin
                if (mem.mem_valid) begin
                    sram_cs_o   = 1'b1;
                    sram_wren_o = |mem.mem_req.wstrb;
                    sram_addr_o = mem.mem_req.addr[ADDR_WIDTH+1:2];
                    sram_data_o = mem.mem_req.wdata;
                    sram_mask_o = mem.mem_req.wstrb;
                    if (|mem.mem_req.wstrb) begin
                        state_d = ST_RESP;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                rdata_d = sram_data_i;
                state_d = ST_RESP;
                ready_d = 1'b1;
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = RST_STATE;
            end
        endcase

        // Reset blocks any SRAM access in the same cycle
        if (rst_i) begin
            sram_cs_o   = 1'b0;
            sram_wren_o = 1'b0;
            sram_mask_o = '0;
        end
    end

    assign mem.mem_ready = ready_q;
    assign mem.mem_rdata = rdata_q;
    assign init_done_o   = done_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural 1024x32 SRAM and a
// scoreboard of expected responses.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_i;
    logic              init_done;
    logic              sram_cs;
    logic              sram_wren;
    logic [9:0]        sram_addr;
    logic [31:0]       sram_wdata;
    logic [3:0]        sram_mask;
    logic [31:0]       sram_rdata;

    sram_ctrl_if bus ();

    sram_ctrl #(.ADDR_WIDTH(10), .INIT_EN(1'b1)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .mem         (bus),
        .init_done_o (init_done),
        .sram_cs_o   (sram_cs),
        .sram_wren_o (sram_wren),
        .sram_addr_o (sram_addr),
        .sram_data_o (sram_wdata),
        .sram_mask_o (sram_mask),
        .sram_data_i (sram_rdata)
    );

    // Behavioural SRAM: masked byte writes, registered read
    logic [31:0] sram_mem [SRAM_DEPTH];
    always @(posedge clk) begin
        if (sram_cs) begin
            if (sram_wren) begin
                for (int b = 0; b < 4; b++)
                    if (sram_mask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
            end else begin
                sram_rdata <= sram_mem[sram_addr];
            end
        end
    end

    typedef struct {
        bit          rd;
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Issue one request at a negedge, wait for ready and score it
    task automatic bus_req(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input logic [31:0] exp_rd, input int exp_lat,
                           input bit drop_valid, input bit chk_pins);
        int   n;
        int   cs_err;
        bit   got;
        exp_t e;
        bus.mem_valid       = 1'b1;
        bus.mem_req.addr    = addr;
        bus.mem_req.wdata   = wdata;
        bus.mem_req.wstrb   = strb;
        exp_q.push_back('{rd: (strb == 4'h0), data: exp_rd, lat: exp_lat});
        #1;
        if (chk_pins) begin
            chk({tag, "_cs"},   32'(sram_cs), 32'd1);
            chk({tag, "_wren"}, 32'(sram_wren), 32'(|strb));
            chk({tag, "_addr"}, 32'(sram_addr), 32'(addr[11:2]));
            chk({tag, "_mask"}, 32'(sram_mask), 32'(strb));
        end
        n = 0; cs_err = 0; got = 1'b0;
        while (!got && n < exp_lat + 8) begin
            @(posedge clk);
            @(negedge clk);
            n++;
            if (drop_valid && n == 1) bus.mem_valid = 1'b0;
            if (chk_pins && sram_cs) cs_err++;
            if (bus.mem_ready) got = 1'b1;
        end
        bus.mem_valid = 1'b0;
        chk({tag, "_seen"}, 32'(got), 32'd1);
        e = exp_q.pop_front();
        if (got) begin
            chk({tag, "_lat"}, 32'(n), 32'(e.lat));
            if (e.rd) chk({tag, "_rdata"}, bus.mem_rdata, e.data);
            if (chk_pins) chk({tag, "_cs_idle"}, 32'(cs_err), 32'd0);
            @(posedge clk);
            @(negedge clk);
            chk({tag, "_pulse"}, 32'(bus.mem_ready), 32'd0);
        end
    endtask

    initial begin
        int sweep_err;
        int flag_err;

        // Reset with a request pending: no access, outputs cleared
        rst_i             = 1'b1;
        bus.mem_valid     = 1'b1;
        bus.mem_req.addr  = 32'h0000_0040;
        bus.mem_req.wdata = 32'h0;
        bus.mem_req.wstrb = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rst_rdata", bus.mem_rdata, 32'd0);
        chk("rst_done",  32'(init_done), 32'd0);
        chk("rst_cs",    32'(sram_cs), 32'd0);
        bus.mem_valid = 1'b0;
        rst_i         = 1'b0;
        #1;

        // Zero-fill sweep over every word
        sweep_err = 0;
        flag_err  = 0;
        for (int k = 0; k < 1024; k++) begin
            if (!(sram_cs && sram_wren && sram_mask == 4'hF && sram_wdata == 32'h0 &&
                  sram_addr == 10'(k))) sweep_err++;
            if (bus.mem_ready || init_done) flag_err++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("init_sweep", 32'(sweep_err), 32'd0);
        chk("init_flags", 32'(flag_err), 32'd0);
        chk("init_done",  32'(init_done), 32'd1);
        chk("init_cs_off", 32'(sram_cs), 32'd0);

        bus_req("rd_3fc", 32'h0000_03FC, 32'h0, 4'h0, 32'h0, 2, 1'b0, 1'b1);
        bus_req("wr_10",  32'h0000_0010, 32'hDEADBEEF, 4'hF, 32'h0, 1, 1'b0, 1'b1);
        bus_req("rd_10",  32'h0000_0010, 32'h0, 4'h0, 32'hDEADBEEF, 2, 1'b0, 1'b1);
        bus_req("wr_14",  32'h0000_0014, 32'h12345678, 4'hF, 32'h0, 1, 1'b0, 1'b1);
        chk("rdata_hold", bus.mem_rdata, 32'hDEADBEEF);
        bus_req("wr_10_part", 32'h0000_0010, 32'h11223344, 4'b0101, 32'h0, 1, 1'b0, 1'b1);
        bus_req("rd_10_part", 32'h0000_0010, 32'h0, 4'h0, 32'hDE22BE44, 2, 1'b0, 1'b1);
        bus_req("wr_alias",   32'h1000_0010, 32'hA1B2C3D4, 4'hF, 32'h0, 1, 1'b0, 1'b1);
        bus_req("rd_alias",   32'h0000_0010, 32'h0, 4'h0, 32'hA1B2C3D4, 2, 1'b0, 1'b1);
        bus_req("rd_drop",    32'h0000_0014, 32'h0, 4'h0, 32'h12345678, 2, 1'b1, 1'b1);
        bus_req("wr_3fc",     32'h0000_03FC, 32'h55AA55AA, 4'hF, 32'h0, 1, 1'b0, 1'b1);

        // Reset while a read waits for SRAM data
        bus.mem_valid     = 1'b1;
        bus.mem_req.addr  = 32'h0000_0010;
        bus.mem_req.wdata = 32'h0;
        bus.mem_req.wstrb = 4'h0;
        @(posedge clk);
        @(negedge clk);
        chk("rdw_no_ready", 32'(bus.mem_ready), 32'd0);
        rst_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rdw_rst_ready", 32'(bus.mem_ready), 32'd0);
        chk("rdw_rst_cs",    32'(sram_cs), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("rdw_rst_ready2", 32'(bus.mem_ready), 32'd0);
        chk("rdw_rst_done",   32'(init_done), 32'd0);
        bus.mem_valid = 1'b0;
        rst_i         = 1'b0;
        #1;
        chk("reinit_cs",   32'(sram_cs), 32'd1);
        chk("reinit_addr", 32'(sram_addr), 32'd0);

        // Write held through the whole sweep: served once init completes
        bus_req("wr_held", 32'h0000_0020, 32'hCAFEF00D, 4'hF, 32'h0, 1025, 1'b0, 1'b0);
        chk("held_done", 32'(init_done), 32'd1);
        bus_req("rd_20",     32'h0000_0020, 32'h0, 4'h0, 32'hCAFEF00D, 2, 1'b0, 1'b1);
        bus_req("rd_10_zf",  32'h0000_0010, 32'h0, 4'h0, 32'h0, 2, 1'b0, 1'b1);
        bus_req("rd_3fc_zf", 32'h0000_03FC, 32'h0, 4'h0, 32'h0, 2, 1'b0, 1'b1);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
